// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and address qualification for the scoreboarded register file.
package regfile_pkg;

   localparam int RF_DEFAULT_DATA_W   = 16;
   localparam int RF_DEFAULT_NUM_REGS = 4;

   // True when addr names a real, writable register (register 0 is dead when zero_reg is set).
   function automatic logic rf_addr_ok(input int addr, input int num_regs, input int zero_reg);
      return addr < num_regs && !(zero_reg != 0 && addr == 0);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits set by claims, cleared by writeback, with sticky double-claim flag.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = RF_DEFAULT_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int ZERO_REG = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic                claim_en,
   input  logic [ADDR_W-1:0]   claim_addr,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic                claim_err
);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                err_q, err_d;
   logic                wr_ok, cl_ok;

   always_comb begin
      wr_ok  = wr_en && rf_addr_ok(32'(wr_addr), NUM_REGS, ZERO_REG);
      cl_ok  = claim_en && rf_addr_ok(32'(claim_addr), NUM_REGS, ZERO_REG);
      busy_d = busy_q;
      err_d  = err_q;
      if (wr_ok) busy_d[wr_addr] = 1'b0;
      // Claim after clear so a same-address write+claim leaves the register busy.
      if (cl_ok) busy_d[claim_addr] = 1'b1;
      if (cl_ok && busy_q[claim_addr] && !(wr_ok && wr_addr == claim_addr)) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign busy_vec  = busy_q;
   assign claim_err = err_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read 1-write register file with busy scoreboard for RAW stall detection.
// Define RF_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DEFAULT_DATA_W,
   parameter int NUM_REGS = RF_DEFAULT_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int ZERO_REG = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   rd_addr1,
   output logic [DATA_W-1:0]   rd_data1,
   output logic                rd_busy1,
   input  logic [ADDR_W-1:0]   rd_addr2,
   output logic [DATA_W-1:0]   rd_data2,
   output logic                rd_busy2,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                claim_en,
   input  logic [ADDR_W-1:0]   claim_addr,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic                claim_err
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic              wr_ok;
`ifdef RF_BYPASS_EN
   logic              cl_ok;
`endif

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .claim_en   (claim_en),
      .claim_addr (claim_addr),
      .busy_vec   (busy_vec),
      .claim_err  (claim_err)
   );

   // Returns {busy, data} for one read port.
   function automatic logic [DATA_W:0] rd_port(input logic [ADDR_W-1:0] a);
      logic hit;
      logic live;
      hit  = 1'b0;
      live = rf_addr_ok(32'(a), NUM_REGS, ZERO_REG);
`ifdef RF_BYPASS_EN
      hit  = wr_ok && a == wr_addr;
      if (hit) return {cl_ok && claim_addr == a, wr_data};
`endif
      return {!hit && rf_addr_ok(32'(a), NUM_REGS, 0) && busy_vec[a],
              live ? regs_q[a] : {DATA_W{1'b0}}};
   endfunction

   always_comb begin
      wr_ok  = wr_en && rf_addr_ok(32'(wr_addr), NUM_REGS, ZERO_REG);
`ifdef RF_BYPASS_EN
      cl_ok  = claim_en && rf_addr_ok(32'(claim_addr), NUM_REGS, ZERO_REG);
`endif
      regs_d = regs_q;
      if (wr_ok) regs_d[wr_addr] = wr_data;
   end

   always_comb begin
      {rd_busy1, rd_data1} = rd_port(rd_addr1);
      {rd_busy2, rd_data2} = rd_port(rd_addr2);
   end

   always_ff @(posedge clk) begin
      if (reset) regs_q <= '{default: '0};
      else regs_q <= regs_d;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: three configurations (4x16, 8x32 zero-reg, 5x8) driven in lockstep against an array model.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        reset, wr_en, claim_en;
   logic [2:0]  wr_addr, claim_addr, rd_addr1, rd_addr2;
   logic [31:0] wr_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   logic [15:0] a_d1, a_d2;
   logic [31:0] b_d1, b_d2;
   logic [7:0]  c_d1, c_d2;
   logic [3:0]  a_bv;
   logic [7:0]  b_bv;
   logic [4:0]  c_bv;
   logic        a_b1, a_b2, a_err, b_b1, b_b2, b_err, c_b1, c_b2, c_err;

   regfile_sb #(.DATA_W(16), .NUM_REGS(4), .ZERO_REG(0)) u_a (
      .clk(clk), .reset(reset),
      .rd_addr1(rd_addr1[1:0]), .rd_data1(a_d1), .rd_busy1(a_b1),
      .rd_addr2(rd_addr2[1:0]), .rd_data2(a_d2), .rd_busy2(a_b2),
      .wr_en(wr_en), .wr_addr(wr_addr[1:0]), .wr_data(wr_data[15:0]),
      .claim_en(claim_en), .claim_addr(claim_addr[1:0]),
      .busy_vec(a_bv), .claim_err(a_err));

   regfile_sb #(.DATA_W(32), .NUM_REGS(8), .ZERO_REG(1)) u_b (
      .clk(clk), .reset(reset),
      .rd_addr1(rd_addr1), .rd_data1(b_d1), .rd_busy1(b_b1),
      .rd_addr2(rd_addr2), .rd_data2(b_d2), .rd_busy2(b_b2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .busy_vec(b_bv), .claim_err(b_err));

   regfile_sb #(.DATA_W(8), .NUM_REGS(5), .ZERO_REG(0)) u_c (
      .clk(clk), .reset(reset),
      .rd_addr1(rd_addr1), .rd_data1(c_d1), .rd_busy1(c_b1),
      .rd_addr2(rd_addr2), .rd_data2(c_d2), .rd_busy2(c_b2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .busy_vec(c_bv), .claim_err(c_err));

   logic [31:0] o_d1 [3], o_d2 [3], o_bv [3], o_b1 [3], o_b2 [3], o_err [3];

   assign o_d1[0] = 32'(a_d1);
   assign o_d1[1] = b_d1;
   assign o_d1[2] = 32'(c_d1);
   assign o_d2[0] = 32'(a_d2);
   assign o_d2[1] = b_d2;
   assign o_d2[2] = 32'(c_d2);
   assign o_bv[0] = 32'(a_bv);
   assign o_bv[1] = 32'(b_bv);
   assign o_bv[2] = 32'(c_bv);
   assign o_b1[0] = 32'(a_b1);
   assign o_b1[1] = 32'(b_b1);
   assign o_b1[2] = 32'(c_b1);
   assign o_b2[0] = 32'(a_b2);
   assign o_b2[1] = 32'(b_b2);
   assign o_b2[2] = 32'(c_b2);
   assign o_err[0] = 32'(a_err);
   assign o_err[1] = 32'(b_err);
   assign o_err[2] = 32'(c_err);

   // Reference model: plain arrays per configuration.
   int          nregs [3] = '{4, 8, 5};
   int          zr    [3] = '{0, 1, 0};
   int          amask [3] = '{3, 7, 7};
   logic [31:0] dmask [3] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h000000FF};
   logic [31:0] m_data [3][8];
   logic        m_busy [3][8];
   logic        m_err  [3];

   function automatic bit live(int i, int a);
      return a < nregs[i] && !(zr[i] != 0 && a == 0);
   endfunction

   function automatic bit w_ok(int i);
      return wr_en && live(i, int'(wr_addr) & amask[i]);
   endfunction

   function automatic bit c_ok(int i);
      return claim_en && live(i, int'(claim_addr) & amask[i]);
   endfunction

   function automatic logic [31:0] exp_d(int i, logic [2:0] r);
      int a = int'(r) & amask[i];
`ifdef RF_BYPASS_EN
      if (w_ok(i) && a == (int'(wr_addr) & amask[i])) return wr_data & dmask[i];
`endif
      if (!live(i, a)) return 32'h0;
      return m_data[i][a];
   endfunction

   function automatic logic [31:0] exp_b(int i, logic [2:0] r);
      int a = int'(r) & amask[i];
`ifdef RF_BYPASS_EN
      if (w_ok(i) && a == (int'(wr_addr) & amask[i]))
         return 32'(c_ok(i) && a == (int'(claim_addr) & amask[i]));
`endif
      if (a >= nregs[i]) return 32'h0;
      return 32'(m_busy[i][a]);
   endfunction

   function automatic logic [31:0] exp_bv(int i);
      logic [31:0] v = '0;
      for (int j = 0; j < nregs[i]; j++) v[j] = m_busy[i][j];
      return v;
   endfunction

   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         bit w, c;
         int wa, ca;
         w  = w_ok(i);
         c  = c_ok(i);
         wa = int'(wr_addr) & amask[i];
         ca = int'(claim_addr) & amask[i];
         if (reset) begin
            for (int j = 0; j < 8; j++) begin
               m_data[i][j] = '0;
               m_busy[i][j] = 1'b0;
            end
            m_err[i] = 1'b0;
         end else begin
            if (c && m_busy[i][ca] && !(w && wa == ca)) m_err[i] = 1'b1;
            if (w) begin
               m_data[i][wa] = wr_data & dmask[i];
               m_busy[i][wa] = 1'b0;
            end
            if (c) m_busy[i][ca] = 1'b1;
         end
      end
   endtask

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, i, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         chk("rd_data1", i, o_d1[i], exp_d(i, rd_addr1));
         chk("rd_data2", i, o_d2[i], exp_d(i, rd_addr2));
         chk("rd_busy1", i, o_b1[i], exp_b(i, rd_addr1));
         chk("rd_busy2", i, o_b2[i], exp_b(i, rd_addr2));
         chk("busy_vec", i, o_bv[i], exp_bv(i));
         chk("claim_err", i, o_err[i], 32'(m_err[i]));
      end
   endtask

   task automatic set(input logic rs, input logic we, input logic [2:0] wa, input logic [31:0] wd,
                      input logic ce, input logic [2:0] ca, input logic [2:0] r1, input logic [2:0] r2);
      @(negedge clk);
      reset = rs; wr_en = we; wr_addr = wa; wr_data = wd;
      claim_en = ce; claim_addr = ca; rd_addr1 = r1; rd_addr2 = r2;
      #1;
   endtask

   task automatic tick();
      check_all();
      @(posedge clk);
      model_step();
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; claim_en = 1'b0;
      wr_addr = '0; claim_addr = '0; rd_addr1 = '0; rd_addr2 = '0; wr_data = '0;
      @(posedge clk);
      model_step();

      // Reset clears written data
      set(0, 1, 1, 32'h0000BEEF, 0, 0, 1, 0); tick();
      set(0, 0, 0, 0, 0, 0, 1, 0);
      chk("t1_pre_reset_data", 0, o_d1[0], 32'h0000BEEF);
      tick();
      set(1, 0, 0, 0, 0, 0, 1, 0); tick();
      set(0, 0, 0, 0, 0, 0, 1, 2);
      chk("t1_reset_data", 0, o_d1[0], 32'h0);
      chk("t1_reset_busy", 0, o_bv[0], 32'h0);
      chk("t1_reset_err", 0, o_err[0], 32'h0);
      tick();

      // Claim then writeback
      set(0, 0, 0, 0, 1, 2, 2, 0); tick();
      set(0, 0, 0, 0, 0, 0, 2, 0);
      chk("t2_busy_after_claim", 0, o_b1[0], 32'h1);
      tick();
      set(0, 1, 2, 32'h00001234, 0, 0, 2, 0); tick();
      set(0, 0, 0, 0, 0, 0, 2, 0);
      chk("t2_data_after_wr", 0, o_d1[0], 32'h00001234);
      chk("t2_busy_after_wr", 0, o_b1[0], 32'h0);
      tick();

      // Same-cycle write and claim to one register
      set(1, 0, 0, 0, 0, 0, 0, 0); tick();
      set(0, 1, 1, 32'h000000AA, 1, 1, 1, 1); tick();
      set(0, 0, 0, 0, 0, 0, 1, 0);
      chk("t4_data", 0, o_d1[0], 32'h000000AA);
      chk("t4_busy_vec", 0, o_bv[0], 32'h2);
      chk("t4_err", 0, o_err[0], 32'h0);
      tick();

      // Double claim sets sticky error
      set(0, 0, 0, 0, 1, 3, 3, 1); tick();
      set(0, 0, 0, 0, 1, 3, 3, 1); tick();
      set(0, 0, 0, 0, 0, 0, 3, 1);
      chk("t3_err_set", 0, o_err[0], 32'h1);
      tick();
      set(0, 1, 3, 32'h00000007, 0, 0, 3, 1); tick();
      set(0, 0, 0, 0, 0, 0, 3, 1);
      chk("t3_err_sticky", 0, o_err[0], 32'h1);
      tick();

      // Write to r0 observed on read port 2 in the same cycle only with bypass
      set(1, 0, 0, 0, 0, 0, 0, 0); tick();
      set(0, 1, 0, 32'h00005555, 0, 0, 1, 0);
`ifdef RF_BYPASS_EN
      chk("t5_bypass", 0, o_d2[0], 32'h00005555);
`else
      chk("t5_no_bypass", 0, o_d2[0], 32'h0);
`endif
      tick();
      set(0, 0, 0, 0, 0, 0, 1, 0);
      chk("t5_next_cycle", 0, o_d2[0], 32'h00005555);
      tick();

      // Zero register ignores write and claim
      set(1, 0, 0, 0, 0, 0, 0, 0); tick();
      set(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
      chk("t6_zero_same_cycle", 1, o_d1[1], 32'h0);
      tick();
      set(0, 0, 0, 0, 0, 0, 0, 0);
      chk("t6_zero_data", 1, o_d1[1], 32'h0);
      chk("t6_zero_busy", 1, o_bv[1], 32'h0);
      chk("t6_zero_err", 1, o_err[1], 32'h0);
      tick();

      // Randomised traffic across all configurations
      for (int n = 0; n < 400; n++) begin
         logic rs;
         rs = ($urandom_range(0, 39) == 0);
         set(rs, !rs && $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
